// File: rtl/run_ctrl.sv
// run_ctrl: debounced single-step, free-run and burst clock enable for the core.
// A sampled hlt parks the block in HALT until the next clr.
module run_ctrl #(
    parameter int DEB_W = 16,
    parameter int DIV_W = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             step_btn,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             hlt,
    output logic             tick,
    output logic             exec,
    output logic             running,
    output logic             busy,
    output logic [CNT_W-1:0] step_count
);

    typedef enum logic [1:0] {
        IDLE,
        FREE,
        BURST,
        HALT
    } state_t;

    localparam logic [DEB_W-1:0] DEB_MAX = '1;
    localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1_q;
    logic             s2_q;
    logic             deb_q;
    logic             deb_d;
    logic             deb_prev_q;
    logic [DEB_W-1:0] dcnt_q;
    logic [DEB_W-1:0] dcnt_d;
    logic             press;

    state_t           state_q;
    logic             tick_q;
    logic             exec_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] rem_q;
    logic [DIV_W-1:0] pre_q;
    logic             pre_tick;

    // Two-flop synchroniser for the raw button.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= step_btn;
            s2_q <= s1_q;
        end
    end

    // Count consecutive cycles the synced level disagrees with the
    // accepted level; accept it once it has held for 2^DEB_W cycles.
    always_comb begin
        dcnt_d = dcnt_q;
        deb_d  = deb_q;
        if (s2_q == deb_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DEB_MAX) begin
            deb_d  = s2_q;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + DEB_ONE;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            dcnt_q     <= '0;
        end else begin
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            dcnt_q     <= dcnt_d;
        end
    end

    assign press    = deb_prev_q & ~deb_q;
    assign pre_tick = (pre_q == div);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            tick_q  <= 1'b0;
            exec_q  <= 1'b1;
            cnt_q   <= '0;
            rem_q   <= '0;
            pre_q   <= '0;
        end else begin
            tick_q <= 1'b0;
            pre_q  <= pre_tick ? '0 : pre_q + DIV_ONE;
            if (tick_q) begin
                cnt_q  <= cnt_q + CNT_ONE;
                exec_q <= 1'b0;
            end
            if (hlt) begin
                state_q <= HALT;
                rem_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (mode == 2'd1) begin
                            state_q <= FREE;
                            pre_q   <= '0;
                        end else if (mode == 2'd2) begin
                            if (press && (burst_len != '0)) begin
                                state_q <= BURST;
                                rem_q   <= burst_len;
                                pre_q   <= '0;
                            end
                        end else if (press) begin
                            tick_q <= 1'b1;
                        end
                    end
                    FREE: begin
                        if (mode != 2'd1) begin
                            state_q <= IDLE;
                        end else begin
                            tick_q <= pre_tick;
                        end
                    end
                    BURST: begin
                        if (pre_tick) begin
                            tick_q <= 1'b1;
                            rem_q  <= rem_q - CNT_ONE;
                            if (rem_q == CNT_ONE) begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    HALT: begin
                        state_q <= HALT;
                    end
                endcase
            end
        end
    end

    assign tick       = tick_q;
    assign exec       = exec_q;
    assign step_count = cnt_q;
    assign running    = (state_q != HALT);
    assign busy       = (state_q == BURST);

endmodule
